fft_input_buffer: RTL and testbench
===================================

# fft_input_buffer

Ping-pong input buffer that sits directly upstream of the 8-point FFT core. It accepts one time-domain sample per clock over a valid/ready stream and stores each 8-sample frame in bit-reversed order. It then presents the complete frame in parallel, with its own valid/ready handshake, to the butterfly stages built from `reg_n` pipeline registers. Two banks let frame k+1 fill while frame k waits to be consumed.

## Interface
- `W`, 16, sample width in bits (two's complement; the block does not interpret the value).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_data`  in  W  incoming sample.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  buffer can accept a sample this cycle.
- `out_data`  out  8*W  parallel frame; slot k occupies `out_data[k*W +: W]`.
- `out_valid`  out  1  a complete frame is on `out_data`.
- `out_ready`  in  1  downstream FFT core takes the frame this cycle.

## Operation
- Storage:
  - Two banks (0, 1), each holding 8 slots of W bits plus a `full` flag.
  - Per-bank state is EMPTY or FULL.
- Write side:
  - `wr_bank` pointer and 3-bit sample index `idx`, both 0 after reset.
  - Sample accept = `in_valid & in_ready`.
  - On accept, `in_data` is written to slot `bitrev3(idx)` of `wr_bank`. The slot order for idx 0..7 is 0,4,2,6,1,5,3,7.
  - After the write, `idx` increments and wraps 7→0.
  - On accept with `idx`==7: `wr_bank` is set FULL and `wr_bank` toggles.
- `in_ready` = 1 when `wr_bank` is EMPTY, else 0. It is combinational from registered state only and never depends on `in_valid`.
- Read side:
  - `rd_bank` pointer, 0 after reset.
  - `out_valid` = `rd_bank` FULL.
  - `out_data` = all 8 slots of `rd_bank`, combinational from the bank registers.
  - Frame transfer = `out_valid & out_ready`. On transfer, `rd_bank` is set EMPTY and `rd_bank` toggles.
  - Slot contents are not cleared on transfer.
- Frames leave in arrival order. Banks alternate strictly 0,1,0,1,…
- Simultaneous events:
  - Completing a fill and transferring in the same cycle is legal whenever the two banks differ; both updates take effect at that edge.
  - `wr_bank` == `rd_bank` with one bank FULL cannot occur with both in the same cycle. The write side only writes an EMPTY bank; the read side only drains a FULL one.
- Both banks FULL → `in_ready`=0 until a transfer. The stalled sample is held by the upstream source, not dropped.
- `out_valid` stays high and `out_data` stays stable until a transfer occurs. `out_ready` may toggle freely.
- Reset, including mid-frame:
  - All slots go to 0 and both banks to EMPTY.
  - `idx`=0, `wr_bank`=0, `rd_bank`=0.
  - A partial frame is discarded; the next accepted sample is sample 0 of a new frame.

## Timing
- Reset values while `rst` is high and on the edge after:
  - `out_valid`=0 and `out_data`=0.
  - `in_ready` is 1 once the reset edge has been taken, because bank 0 is EMPTY.
- Latency: if the 8th sample is accepted at edge t, `out_valid`=1 in the cycle following edge t (1 clock).
- Sustained throughput is 1 sample/clock provided each frame is taken within 8 cycles of `out_valid` rising.
- After a transfer at edge t, the freed bank is EMPTY and `in_ready` reflects it in the cycle after t.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Test plan
- Reset: hold `rst` 3 cycles with `in_valid`=1 → no samples accepted; after release `out_valid`=0, `out_data`=0, `in_ready`=1.
- Single frame with `out_ready`=0:
  - Stimulus: feed samples 16'h0010..16'h0017 (n=0..7) on consecutive cycles.
  - Required: `out_valid`=1 one cycle after the 8th accept.
  - Required slots 0..7 = 0010, 0014, 0012, 0016, 0011, 0015, 0013, 0017.
- Backpressure with `out_ready`=0 and `in_valid`=1 continuously:
  - Exactly 16 samples are accepted, then `in_ready`=0 and stays 0.
  - `out_data` holds frame 0 unchanged.
  - Pulse `out_ready` 1 cycle → frame 1 appears next cycle and `in_ready` returns to 1.
- Simultaneous fill and drain:
  - Setup: frame 0 is waiting; hold `out_ready`=1 while the 8th sample of frame 1 is accepted on the same edge.
  - Required: next cycle `out_valid`=1 with frame 1 data, and the write side has moved to bank 0.
- Reset mid-frame:
  - Accept 5 samples (A0..A4), assert `rst` 1 cycle, then feed 8 new samples B0..B7.
  - Required: the only frame output is B, in bit-reversed order; A data never appears.
- Streaming: 4 back-to-back frames (32 samples, values 0..31) with `out_ready`=1 → `in_ready` never drops, and exactly 4 transfers occur in order with correct bit-reversed contents.

Source files
------------

// File: rtl/fft_input_buffer_if.sv
// ============================================================================
//  Module      : fft_input_buffer_if
//  Description : Sample-in / frame-out stream bundle for the FFT input buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_input_buffer_if #(
    parameter int W = 16
);
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [8*W-1:0] out_data;
    logic           out_valid;
    logic           out_ready;

    // Environment side: drives samples in and accepts frames out.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    // Buffer side.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

`default_nettype wire

// File: rtl/fft_input_buffer.sv
// ============================================================================
//  Module      : fft_input_buffer
//  Description : Two-bank ping-pong buffer; stores 8-sample frames in
//                bit-reversed slot order and presents them in parallel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_input_buffer #(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_input_buffer_if.slave    bus
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_e;

    bank_state_e           bank_state_q [2];
    bank_state_e           bank_state_d [2];
    logic [7:0][W-1:0]     slots_q      [2];
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [2:0]            idx_q, idx_d;
    logic                  accept;
    logic                  transfer;

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    // Handshake outputs depend only on registered bank state.
    assign bus.in_ready  = (bank_state_q[wr_bank_q] == EMPTY);
    assign bus.out_valid = (bank_state_q[rd_bank_q] == FULL);
    assign bus.out_data  = slots_q[rd_bank_q];

    assign accept   = bus.in_valid  & bus.in_ready;
    assign transfer = bus.out_valid & bus.out_ready;

    // Fill and drain never target the same bank in one cycle, so both
    // state updates below can apply independently.
    always_comb begin
        bank_state_d = bank_state_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        idx_d        = idx_q;

        if (accept) begin
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                bank_state_d[wr_bank_q] = FULL;
                wr_bank_d               = ~wr_bank_q;
            end
        end

        if (transfer) begin
            bank_state_d[rd_bank_q] = EMPTY;
            rd_bank_d               = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_state_q[b] <= EMPTY;
                slots_q[b]      <= '0;
            end
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            idx_q     <= 3'd0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_state_q[b] <= bank_state_d[b];
            end
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            idx_q     <= idx_d;
            if (accept) begin
                slots_q[wr_bank_q][bitrev3(idx_q)] <= bus.in_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_input_buffer.sv
// ============================================================================
//  Module      : tb_fft_input_buffer
//  Description : Scoreboard bench for the ping-pong FFT input buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_input_buffer;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_input_buffer_if #(.W(W)) bus ();

    fft_input_buffer #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_xfer   = 0;

    logic [8*W-1:0] sb_q [$];
    logic [8*W-1:0] m_frame;
    logic [2:0]     m_idx;
    logic           e_ready;
    logic           e_valid;
    int             c_slot [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: frames waiting == scoreboard depth.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            m_idx   = 3'd0;
            m_frame = '0;
        end else begin
            e_ready = (sb_q.size() < 2);
            e_valid = (sb_q.size() > 0);
            chk("in_ready", {127'd0, bus.in_ready}, {127'd0, e_ready});
            chk("out_valid", {127'd0, bus.out_valid}, {127'd0, e_valid});
            if (e_valid) begin
                chk("out_data", bus.out_data, sb_q[0]);
                if (bus.out_ready) begin
                    void'(sb_q.pop_front());
                    n_xfer++;
                end
            end
            if (e_ready && bus.in_valid) begin
                m_frame[c_slot[m_idx]*W +: W] = bus.in_data;
                n_acc++;
                if (m_idx == 3'd7) sb_q.push_back(m_frame);
                m_idx = m_idx + 3'd1;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Offer n consecutive values starting at base; returns cycles taken.
    task automatic stream(input int n, input int base, input int maxc, output int cycles);
        int start;
        int cnt;
        start        = n_acc;
        cnt          = 0;
        cycles       = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = W'(base);
        while (cnt < n && cycles < maxc) begin
            cycle();
            cycles++;
            if (n_acc != start + cnt) begin
                cnt         = n_acc - start;
                bus.in_data = W'(base + cnt);
            end
        end
        bus.in_valid = 1'b0;
        if (cnt < n) chk("stream_timeout", 128'(cnt), 128'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int a0;
        int x0;

        // Reset held 3 cycles with a sample offered.
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hdead;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) cycle();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("rst_out_data", bus.out_data, 128'd0);
        chk("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);

        // Single frame, downstream stalled.
        stream(8, 'h10, 20, cyc);
        chk("single_cycles", 128'(cyc), 128'd8);
        chk("single_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("single_data", bus.out_data, 128'h0017_0013_0015_0011_0016_0012_0014_0010);

        // Backpressure: exactly 16 accepted, then stall.
        do_reset();
        stream(16, 'h100, 40, cyc);
        chk("bp_cycles", 128'(cyc), 128'd16);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h01ff;
        a0           = n_acc;
        repeat (5) cycle();
        chk("bp_no_accept", 128'(n_acc - a0), 128'd0);
        chk("bp_ready_low", {127'd0, bus.in_ready}, 128'd0);
        chk("bp_hold_f0", bus.out_data, 128'h0107_0103_0105_0101_0106_0102_0104_0100);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        chk("bp_f1", bus.out_data, 128'h010f_010b_010d_0109_010e_010a_010c_0108);
        chk("bp_ready_back", {127'd0, bus.in_ready}, 128'd1);
        bus.in_valid = 1'b0;
        chk("bp_still_no_accept", 128'(n_acc - a0), 128'd0);
        bus.out_ready = 1'b1;
        repeat (2) cycle();
        bus.out_ready = 1'b0;

        // Fill of bank 1 and drain of bank 0 on the same edge.
        do_reset();
        stream(8, 'h200, 20, cyc);
        stream(7, 'h208, 20, cyc);
        bus.out_ready = 1'b1;
        stream(1, 'h20f, 5, cyc);
        bus.out_ready = 1'b0;
        chk("sim_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("sim_f1", bus.out_data, 128'h020f_020b_020d_0209_020e_020a_020c_0208);
        chk("sim_ready", {127'd0, bus.in_ready}, 128'd1);
        stream(8, 'h300, 20, cyc);
        chk("sim_bank0_full", {127'd0, bus.in_ready}, 128'd0);
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        bus.out_ready = 1'b0;

        // Reset mid-frame discards the partial frame.
        do_reset();
        stream(5, 'ha0, 20, cyc);
        do_reset();
        x0 = n_xfer;
        chk("mr_out_data_zero", bus.out_data, 128'd0);
        stream(8, 'hb0, 20, cyc);
        chk("mr_frame_b", bus.out_data, 128'h00b7_00b3_00b5_00b1_00b6_00b2_00b4_00b0);
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        bus.out_ready = 1'b0;
        chk("mr_xfers", 128'(n_xfer - x0), 128'd1);

        // Four back-to-back frames at full rate.
        do_reset();
        bus.out_ready = 1'b1;
        x0 = n_xfer;
        stream(32, 0, 100, cyc);
        chk("stream_cycles", 128'(cyc), 128'd32);
        repeat (3) cycle();
        bus.out_ready = 1'b0;
        chk("stream_xfers", 128'(n_xfer - x0), 128'd4);
        chk("sb_empty", 128'(sb_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
